map_hit_decoder: RTL and testbench

- Inverse of the map drawing path. Takes a screen pixel (x,y) from a tank or bullet mover and decides whether that pixel is a solid brick pixel of the active map.
- Decodes the pixel to a tile column/row and an in-tile pixel offset, queries the external map ROM, and applies the fixed 9x9 brick pattern.
- Sits between the tank/bullet movement FSMs and the shared map ROM.
- Uses a req/done handshake with an iterative divide-by-9, so there is one query in flight at a time.

---
 rtl/map_hit_decoder.sv | 166 ++++++++++++++++
 tb/tb_map_hit_decoder.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/map_hit_decoder.sv
// map_hit_decoder: turns a screen pixel into a "solid brick?" answer.
// The pixel is first rebased to the map origin, then split into a tile
// column/row and an in-tile offset by repeated subtraction of the tile pitch.
// The tile column/row addresses the external map ROM, and the offset selects
// a bit of the fixed brick pattern drawn inside every tile.
module map_hit_decoder #(
  parameter int X_ORIGIN = 21,
  parameter int Y_ORIGIN = 1,
  parameter int TILE     = 9,
  parameter int GRID     = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       req,
  input  logic [7:0] qx,
  input  logic [6:0] qy,
  output logic [7:0] map_addr,
  input  logic       map_bit,
  output logic       busy,
  output logic       done,
  output logic       hit,
  output logic       tile_hit,
  output logic       oob,
  output logic [3:0] tile_col,
  output logic [3:0] tile_row,
  output logic [1:0] dbg_state
);

  // Handshake: req is looked at only while the block is idle (busy=0). A req
  // seen in IDLE starts exactly one query; req while busy is dropped, not
  // queued. done pulses for one cycle when the result outputs become valid,
  // and the results then hold until the next accepted req.

  // Screen-space limits of the tiled area, sized to the comparison operands.
  localparam logic [8:0] X_LO  = 9'(X_ORIGIN);
  localparam logic [8:0] X_HI  = 9'(X_ORIGIN + TILE * GRID - 1);
  localparam logic [7:0] Y_LO  = 8'(Y_ORIGIN);
  localparam logic [7:0] Y_HI  = 8'(Y_ORIGIN + TILE * GRID - 1);
  localparam logic [8:0] X_STEP = 9'(TILE);
  localparam logic [7:0] Y_STEP = 8'(TILE);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIV    = 2'd1,
    S_LOOKUP = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t     state;
  logic [8:0] xr;
  logic [7:0] yr;
  logic [3:0] col;
  logic [3:0] row;

  logic [8:0] qx_ext;
  logic [7:0] qy_ext;
  logic       query_oob;
  logic       x_more;
  logic       y_more;
  logic       brick;

  // Brick pattern inside one tile: three double-rows of bricks separated by
  // mortar rows, with the vertical joint shifted on every double-row.
  function automatic logic brick_at(input logic [3:0] px, input logic [3:0] py);
    logic b;
    b = 1'b0;
    case (py)
      4'd0, 4'd8: b = (px != 4'd1);
      4'd2, 4'd3: b = (px != 4'd4);
      4'd5, 4'd6: b = (px != 4'd7);
      default:    b = 1'b0;
    endcase
    return b;
  endfunction

  // Bounds test runs on the raw request coordinates so that negative
  // rebased values never reach the divider.
  always_comb begin
    qx_ext    = {1'b0, qx};
    qy_ext    = {1'b0, qy};
    query_oob = (qx_ext < X_LO) || (qx_ext > X_HI) ||
                (qy_ext < Y_LO) || (qy_ext > Y_HI);
    x_more    = (xr >= X_STEP);
    y_more    = (yr >= Y_STEP);
    brick     = brick_at(xr[3:0], yr[3:0]);
  end

  // Query sequencer: accept, divide both axes in parallel, read ROM, report.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      xr       <= '0;
      yr       <= '0;
      col      <= '0;
      row      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hit      <= 1'b0;
      tile_hit <= 1'b0;
      oob      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (req) begin
            xr       <= qx_ext - X_LO;
            yr       <= qy_ext - Y_LO;
            col      <= '0;
            row      <= '0;
            tile_hit <= 1'b0;
            busy     <= 1'b1;
            if (query_oob) begin
              // Anything off the map counts as solid so movers stop at the edge.
              oob   <= 1'b1;
              hit   <= 1'b1;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              oob   <= 1'b0;
              hit   <= 1'b0;
              state <= S_DIV;
            end
          end
        end
        S_DIV: begin
          if (x_more || y_more) begin
            if (x_more) begin
              xr  <= xr - X_STEP;
              col <= col + 4'd1;
            end
            if (y_more) begin
              yr  <= yr - Y_STEP;
              row <= row + 4'd1;
            end
          end else begin
            state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          tile_hit <= map_bit;
          hit      <= map_bit & brick;
          done     <= 1'b1;
          state    <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // The ROM address follows the quotient registers; it is only meaningful
  // once the divide has finished, i.e. in LOOKUP.
  assign map_addr  = {col, row};
  assign tile_col  = col;
  assign tile_row  = row;
  assign dbg_state = state;

endmodule

// File: tb/tb_map_hit_decoder.sv
// Testbench for map_hit_decoder: directed cases, randomized queries against a
// tile/offset reference model, busy-time request drops, held-req restart and
// asynchronous reset during a query.
module tb_map_hit_decoder;

  logic       clk;
  logic       resetn;
  logic       req;
  logic [7:0] qx;
  logic [6:0] qy;
  logic [7:0] map_addr;
  logic       map_bit;
  logic       busy;
  logic       done;
  logic       hit;
  logic       tile_hit;
  logic       oob;
  logic [3:0] tile_col;
  logic [3:0] tile_row;
  logic [1:0] dbg_state;

  logic rom [256];

  int tests_run;
  int tests_failed;

  map_hit_decoder dut (
    .clk      (clk),
    .resetn   (resetn),
    .req      (req),
    .qx       (qx),
    .qy       (qy),
    .map_addr (map_addr),
    .map_bit  (map_bit),
    .busy     (busy),
    .done     (done),
    .hit      (hit),
    .tile_hit (tile_hit),
    .oob      (oob),
    .tile_col (tile_col),
    .tile_row (tile_row),
    .dbg_state(dbg_state)
  );

  // Clock and combinational map ROM.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  assign map_bit = rom[map_addr];

  // Reference model: {hit, tile_hit, oob, col[3:0], row[3:0]} from plain
  // division of the rebased pixel by the tile pitch.
  function automatic logic [10:0] model_res(input int x, input int y);
    int c, r, px, py;
    logic brick, tb;
    if (x < 21 || x > 164 || y < 1 || y > 144) return {1'b1, 1'b0, 1'b1, 8'h00};
    c  = (x - 21) / 9;
    r  = (y - 1) / 9;
    px = (x - 21) % 9;
    py = (y - 1) % 9;
    if (py == 0 || py == 8)      brick = (px != 1);
    else if (py == 2 || py == 3) brick = (px != 4);
    else if (py == 5 || py == 6) brick = (px != 7);
    else                         brick = 1'b0;
    tb = rom[c * 16 + r];
    return {tb & brick, tb, 1'b0, 4'(c), 4'(r)};
  endfunction

  function automatic int model_lat(input int x, input int y);
    int c, r;
    if (x < 21 || x > 164 || y < 1 || y > 144) return 1;
    c = (x - 21) / 9;
    r = (y - 1) / 9;
    return 3 + ((c > r) ? c : r);
  endfunction

  // Driver: issue one query and observe it. lat counts cycles after the accept
  // cycle up to done (-1 on timeout); after holds {done, results} one cycle later.
  task automatic do_query(input logic [7:0] x, input logic [6:0] y,
                          output logic [10:0] obs, output logic [7:0] addr,
                          output int lat, output int bcyc, output logic [11:0] after);
    int n;
    @(negedge clk);
    qx  = x;
    qy  = y;
    req = 1'b1;
    @(negedge clk);
    req  = 1'b0;
    n    = 1;
    bcyc = 0;
    while (done !== 1'b1 && n < 40) begin
      bcyc += (busy === 1'b1) ? 1 : 0;
      @(negedge clk);
      n++;
    end
    bcyc += (busy === 1'b1) ? 1 : 0;
    lat   = (done === 1'b1) ? n : -1;
    obs   = {hit, tile_hit, oob, tile_col, tile_row};
    addr  = map_addr;
    @(negedge clk);
    after = {done, hit, tile_hit, oob, tile_col, tile_row};
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    req    = 1'b0;
    qx     = '0;
    qy     = '0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({busy, done, hit, tile_hit, oob, tile_col, tile_row, map_addr, dbg_state} !== 23'd0) begin
      tests_failed++;
      $display("FAIL reset_state: got %h want 0",
               {busy, done, hit, tile_hit, oob, tile_col, tile_row, map_addr, dbg_state});
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    int          xs[8] = '{21, 22, 53, 53, 20, 165, 30, 164};
    int          ys[8] = '{1, 1, 48, 48, 10, 10, 0, 127};
    logic        bs[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [10:0] obs, exp;
    logic [7:0]  addr;
    logic [11:0] after;
    int          lat, bcyc, elat;
    for (int i = 0; i < 8; i++) begin
      if (xs[i] >= 21 && xs[i] <= 164 && ys[i] >= 1)
        rom[((xs[i] - 21) / 9) * 16 + (ys[i] - 1) / 9] = bs[i];
      exp  = model_res(xs[i], ys[i]);
      elat = model_lat(xs[i], ys[i]);
      do_query(8'(xs[i]), 7'(ys[i]), obs, addr, lat, bcyc, after);
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL directed_result[%0d]: got %h want %h", i, obs, exp);
      end
      tests_run++;
      if (addr !== exp[7:0]) begin
        tests_failed++;
        $display("FAIL directed_map_addr[%0d]: got %h want %h", i, addr, exp[7:0]);
      end
      tests_run++;
      if (lat !== elat || bcyc !== elat) begin
        tests_failed++;
        $display("FAIL directed_latency[%0d]: got lat %0d busy %0d want %0d", i, lat, bcyc, elat);
      end
      tests_run++;
      if (after !== {1'b0, exp}) begin
        tests_failed++;
        $display("FAIL directed_hold[%0d]: got %h want %h", i, after, {1'b0, exp});
      end
    end
  endtask

  task automatic test_random();
    logic [10:0] obs, exp;
    logic [7:0]  addr;
    logic [11:0] after;
    int          lat, bcyc, elat, x, y;
    for (int i = 0; i < 256; i++) rom[i] = 1'($urandom_range(0, 1));
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 9) < 8) begin
        x = $urandom_range(21, 164);
        y = $urandom_range(1, 127);
      end else begin
        x = $urandom_range(0, 255);
        y = $urandom_range(0, 127);
      end
      exp  = model_res(x, y);
      elat = model_lat(x, y);
      do_query(8'(x), 7'(y), obs, addr, lat, bcyc, after);
      tests_run++;
      if (obs !== exp || addr !== exp[7:0]) begin
        tests_failed++;
        $display("FAIL random_result(%0d,%0d): got %h addr %h want %h", x, y, obs, addr, exp);
      end
      tests_run++;
      if (lat !== elat || bcyc !== elat || after !== {1'b0, exp}) begin
        tests_failed++;
        $display("FAIL random_timing(%0d,%0d): got lat %0d busy %0d after %h want %0d / %h",
                 x, y, lat, bcyc, after, elat, {1'b0, exp});
      end
    end
  endtask

  task automatic test_req_during_div();
    logic [10:0] first, exp;
    int          ndone, first_at;
    rom[8'h35] = 1'b1;
    exp   = model_res(53, 48);
    ndone = 0;
    first_at = -1;
    first = '0;
    @(negedge clk);
    qx  = 8'd53;
    qy  = 7'd48;
    req = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 1) req = 1'b0;
      if (n == 3) begin
        qx  = 8'd21;
        qy  = 7'd1;
        req = 1'b1;
      end
      if (n == 4) req = 1'b0;
      if (done === 1'b1) begin
        if (ndone == 0) begin
          first    = {hit, tile_hit, oob, tile_col, tile_row};
          first_at = n;
        end
        ndone++;
      end
    end
    tests_run++;
    if (ndone != 1 || first_at != 8) begin
      tests_failed++;
      $display("FAIL busy_req_ignored: got %0d dones first at %0d want 1 at 8", ndone, first_at);
    end
    tests_run++;
    if (first !== exp) begin
      tests_failed++;
      $display("FAIL busy_req_result: got %h want %h", first, exp);
    end
  endtask

  task automatic test_back_to_back();
    int dq[$];
    rom[8'h00] = 1'b1;
    @(negedge clk);
    qx  = 8'd21;
    qy  = 7'd1;
    req = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (done === 1'b1) dq.push_back(n);
    end
    req = 1'b0;
    repeat (25) @(negedge clk);
    tests_run++;
    if (dq.size() < 2) begin
      tests_failed++;
      $display("FAIL held_req_restart: got %0d dones want 2", dq.size());
    end else if (dq[0] != 3 || dq[1] != 7) begin
      tests_failed++;
      $display("FAIL held_req_restart: got dones at %0d,%0d want 3,7", dq[0], dq[1]);
    end
  endtask

  task automatic test_reset_mid_query();
    logic [10:0] obs, exp;
    logic [7:0]  addr;
    logic [11:0] after;
    int          lat, bcyc, ndone;
    @(negedge clk);
    qx  = 8'd164;
    qy  = 7'd127;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (3) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    tests_run++;
    if ({busy, done, hit, tile_hit, oob, tile_col, tile_row, map_addr} !== 21'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_query: got %h want 0",
               {busy, done, hit, tile_hit, oob, tile_col, tile_row, map_addr});
    end
    @(negedge clk);
    resetn = 1'b1;
    ndone  = 0;
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    tests_run++;
    if (ndone != 0) begin
      tests_failed++;
      $display("FAIL reset_no_stale_done: got %0d dones want 0", ndone);
    end
    rom[8'h35] = 1'b1;
    exp = model_res(53, 48);
    do_query(8'd53, 7'd48, obs, addr, lat, bcyc, after);
    tests_run++;
    if (obs !== exp || lat != 8) begin
      tests_failed++;
      $display("FAIL reset_then_query: got %h lat %0d want %h lat 8", obs, lat, exp);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    for (int i = 0; i < 256; i++) rom[i] = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_req_during_div();
    test_back_to_back();
    test_reset_mid_query();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
